pcfx_bkram_sd: RTL and testbench

// Moves the 32 KiB backup-RAM image between the MiSTer SD block interface
// (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*) and the on-chip backup RAM.
// On bk_load it reads the image into the RAM; on bk_save it writes the RAM back.

---
 rtl/pcfx_bkram_sd_pkg.sv | 11 +
 rtl/pcfx_bkram_sd.sv | 108 ++++++++++
 tb/tb_pcfx_bkram_sd.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcfx_bkram_sd_pkg.sv
// pcfx_bkram_sd_pkg: constants, transfer state type and image sizing helper
// for the backup-RAM SD mover.
package pcfx_bkram_sd_pkg;
    localparam int BK_SECTORS      = 64;
    localparam int BK_SECTOR_WORDS = 256;
    typedef enum logic [1:0] {IDLE, REQ, XFER, NEXT} bk_state_t;
    // Whole 512-byte sectors in the image, clamped to what the RAM holds
    function automatic int unsigned sect_count(input logic [63:0] size, input int unsigned max_sect);
        return (size[63:9] > 55'(max_sect)) ? max_sect : 32'(size[40:9]);
    endfunction
endpackage

// File: rtl/pcfx_bkram_sd.sv
// pcfx_bkram_sd: streams the backup-RAM image between the HPS SD block
// interface and port B of the backup-RAM DPRAM on load/save requests.
module pcfx_bkram_sd
    import pcfx_bkram_sd_pkg::*;
#(
    parameter int SECTORS = BK_SECTORS,
    parameter int RAM_AW  = 14
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              img_mounted,
    input  logic              img_readonly,
    input  logic [63:0]       img_size,
    input  logic              bk_load,
    input  logic              bk_save,
    output logic              bk_ena,
    output logic              bk_loading,
    output logic              bk_saving,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    input  logic [7:0]        sd_buff_addr,
    input  logic [15:0]       sd_buff_dout,
    input  logic              sd_buff_wr,
    output logic [15:0]       sd_buff_din,
    output logic [RAM_AW-1:0] bram_addr,
    output logic              bram_we,
    output logic [15:0]       bram_wdata,
    input  logic [15:0]       bram_rdata
);
    localparam int SW = RAM_AW - $clog2(BK_SECTOR_WORDS);
    localparam int NW = SW + 1;

    bk_state_t     state, state_nx;
    logic [SW-1:0] sector;
    logic [NW-1:0] mnt_nsect, op_nsect, new_nsect;
    logic          load_d, save_d, load_go, save_go, last;

    assign new_nsect = NW'(sect_count(img_size, SECTORS));
    assign load_go   = bk_load && !load_d && bk_ena;
    assign save_go   = bk_save && !save_d && bk_ena && !img_readonly;
    assign last      = {1'b0, sector} == op_nsect - NW'(1);
    assign sd_lba    = 32'(sector);

    always_comb begin
        state_nx    = state;
        sd_rd       = 1'b0;
        sd_wr       = 1'b0;
        bram_we     = 1'b0;
        bram_addr   = '0;
        bram_wdata  = '0;
        sd_buff_din = '0;
        case (state)
            IDLE: state_nx = (load_go || save_go) ? REQ : IDLE;
            REQ: begin
                sd_rd    = bk_loading;
                sd_wr    = bk_saving;
                state_nx = sd_ack ? XFER : REQ;
            end
            XFER: begin
                bram_we  = bk_loading && sd_buff_wr;
                state_nx = sd_ack ? XFER : NEXT;
            end
            default: state_nx = last ? IDLE : REQ;
        endcase
        if (bram_we || bk_saving) bram_addr = {sector, sd_buff_addr};
        if (bram_we) bram_wdata = sd_buff_dout;
        if (bk_saving) sd_buff_din = bram_rdata;
    end

    // The sector count is captured at op start so a mount mid-transfer only affects the next op
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sector     <= '0;
            mnt_nsect  <= '0;
            op_nsect   <= '0;
            load_d     <= 1'b0;
            save_d     <= 1'b0;
            bk_ena     <= 1'b0;
            bk_loading <= 1'b0;
            bk_saving  <= 1'b0;
        end else begin
            state  <= state_nx;
            load_d <= bk_load;
            save_d <= bk_save;
            if (img_mounted) begin
                mnt_nsect <= new_nsect;
                bk_ena    <= new_nsect != '0;
            end
            if (state == IDLE && state_nx == REQ) begin
                sector     <= '0;
                op_nsect   <= mnt_nsect;
                bk_loading <= load_go;
                bk_saving  <= !load_go;
            end
            if (state == NEXT) begin
                if (last) begin
                    bk_loading <= 1'b0;
                    bk_saving  <= 1'b0;
                end else begin
                    sector <= sector + SW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_pcfx_bkram_sd.sv
// tb_pcfx_bkram_sd: HPS/SD and DPRAM models around pcfx_bkram_sd with an
// expected-RAM scoreboard and per-cycle output checks.
module tb_pcfx_bkram_sd;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        img_mounted = 1'b0;
    logic        img_readonly = 1'b0;
    logic [63:0] img_size = '0;
    logic        bk_load = 1'b0;
    logic        bk_save = 1'b0;
    logic        bk_ena, bk_loading, bk_saving;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic        sd_ack = 1'b0;
    logic [7:0]  sd_buff_addr = '0;
    logic [15:0] sd_buff_dout = '0;
    logic        sd_buff_wr = 1'b0;
    logic [15:0] sd_buff_din;
    logic [13:0] bram_addr;
    logic        bram_we;
    logic [15:0] bram_wdata;
    logic [15:0] bram_rdata = '0;

    int checks = 0;
    int errors = 0;
    logic        m_ena = 1'b0;
    logic        cmp_on = 1'b0;
    logic        stray = 1'b0;
    logic        hps_load = 1'b0;
    logic [31:0] hps_lba = '0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          since = 0;
    logic [31:0] lbas[$];
    logic [15:0] cap[$];
    logic [15:0] ram[16384];
    logic [15:0] exp_ram[16384];
    logic [15:0] img[16384];

    pcfx_bkram_sd dut (
        .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_readonly(img_readonly),
        .img_size(img_size), .bk_load(bk_load), .bk_save(bk_save), .bk_ena(bk_ena),
        .bk_loading(bk_loading), .bk_saving(bk_saving), .sd_lba(sd_lba), .sd_rd(sd_rd),
        .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .bram_addr(bram_addr),
        .bram_we(bram_we), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [15:0] fill(input int seed, input int i);
        return 16'((seed << 12) ^ (i * 5));
    endfunction

    function automatic logic [15:0] ram0(input int i);
        return 16'(32'hA000 ^ i);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Backup-RAM port B: registered read, write on bram_we
    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = ram0(i);
        forever begin
            @(posedge clk_sys);
            bram_rdata <= ram[bram_addr];
            if (bram_we) ram[bram_addr] = bram_wdata;
        end
    end

    // HPS side: serves one sector per request, holds save addresses 2 cycles
    initial begin
        forever begin
            @(negedge clk_sys);
            if (!reset && (sd_rd || sd_wr)) begin
                if (sd_lba != 0) chk("sector_gap", since, 1);
                lbas.push_back(sd_lba);
                hps_load = sd_rd;
                if (sd_rd) rd_cnt++;
                else wr_cnt++;
                @(negedge clk_sys);
                chk("req_hold", 32'({sd_rd, sd_wr}), hps_load ? 2 : 1);
                hps_lba = sd_lba;
                sd_ack = 1'b1;
                @(negedge clk_sys);
                chk("req_drop", 32'({sd_rd, sd_wr}), 0);
                for (int w = 0; w < 256 && !reset; w++) begin
                    sd_buff_addr = 8'(w);
                    if (hps_load) begin
                        sd_buff_dout = img[hps_lba * 256 + w];
                        sd_buff_wr = 1'b1;
                        @(negedge clk_sys);
                    end else begin
                        sd_buff_wr = 1'b0;
                        @(negedge clk_sys);
                        @(negedge clk_sys);
                        cap.push_back(sd_buff_din);
                    end
                end
                sd_buff_wr = 1'b0;
                sd_ack = 1'b0;
                since = 0;
            end else begin
                since++;
                sd_buff_wr = stray;
                sd_buff_addr = 8'h33;
                sd_buff_dout = 16'hDEAD;
            end
        end
    end

    // Per-cycle output check against the bench's view of the transfer
    always begin
        @(posedge clk_sys);
        #1;
        if (cmp_on && !reset) begin
            chk("bk_ena", 32'(bk_ena), 32'(m_ena));
            chk("rd_wr_excl", 32'(sd_rd & sd_wr), 0);
            chk("bram_we", 32'(bram_we), 32'(sd_ack & hps_load & sd_buff_wr));
            if (bram_we) begin
                chk("load_addr", 32'(bram_addr), (hps_lba << 8) | 32'(sd_buff_addr));
                chk("load_data", 32'(bram_wdata), 32'(sd_buff_dout));
            end
            if (sd_ack && !hps_load) chk("save_addr", 32'(bram_addr), (hps_lba << 8) | 32'(sd_buff_addr));
            if (!bk_loading && !bk_saving) chk("idle_addr", 32'(bram_addr), 0);
        end
    end

    task automatic set_img(input int seed);
        for (int i = 0; i < 16384; i++) img[i] = fill(seed, i);
    endtask

    task automatic mount(input logic [63:0] sz, input logic ena);
        @(negedge clk_sys);
        img_size = sz;
        img_mounted = 1'b1;
        m_ena = ena;
        @(negedge clk_sys);
        img_mounted = 1'b0;
        chk("mount_ena", 32'(bk_ena), 32'(ena));
    endtask

    task automatic cmp_ram(input string nm, input int lo, input int hi);
        int bad = 0;
        for (int i = 0; i < 16384; i++)
            if (!(i >= lo && i < hi) && ram[i] !== exp_ram[i]) bad++;
        chk(nm, bad, 0);
    endtask

    task automatic run_op(input string nm, input logic ld, input logic sv, input int exp_n, input int poke);
        int rb, wb, lb, cb, t, bad, late;
        rb = rd_cnt;
        wb = wr_cnt;
        lb = lbas.size();
        cb = cap.size();
        @(negedge clk_sys);
        bk_load = ld;
        bk_save = sv;
        @(negedge clk_sys);
        chk({nm, "_busy"}, 32'({bk_loading, bk_saving}), (exp_n == 0) ? 0 : (ld ? 2 : 1));
        t = 0;
        while ((bk_loading || bk_saving) && t < 40000) begin
            @(negedge clk_sys);
            t++;
            if (t == poke) begin
                bk_load = 1'b1;
                img_size = 64'd1024;
                img_mounted = 1'b1;
            end
            if (t == poke + 1) img_mounted = 1'b0;
            if (t == poke + 5) bk_load = 1'b0;
        end
        chk({nm, "_timeout"}, 32'(t < 40000), 1);
        bk_load = 1'b0;
        bk_save = 1'b0;
        late = 0;
        repeat (20) begin
            @(negedge clk_sys);
            if (bk_loading || bk_saving || sd_rd || sd_wr) late++;
        end
        chk({nm, "_quiet"}, late, 0);
        chk({nm, "_rd_cnt"}, rd_cnt - rb, ld ? exp_n : 0);
        chk({nm, "_wr_cnt"}, wr_cnt - wb, (!ld && sv) ? exp_n : 0);
        bad = 0;
        for (int k = 0; k < exp_n; k++)
            if (lbas.size() <= lb + k || lbas[lb + k] != 32'(k)) bad++;
        chk({nm, "_lba_seq"}, bad, 0);
        if (ld) begin
            for (int i = 0; i < exp_n * 256; i++) exp_ram[i] = img[i];
            cmp_ram({nm, "_ram"}, 0, 0);
        end else if (sv && exp_n > 0) begin
            chk({nm, "_cap_len"}, cap.size() - cb, exp_n * 256);
            bad = 0;
            for (int i = 0; i < exp_n * 256 && cb + i < cap.size(); i++)
                if (cap[cb + i] !== exp_ram[i]) bad++;
            chk({nm, "_cap_data"}, bad, 0);
        end
    endtask

    initial begin
        int t;
        for (int i = 0; i < 16384; i++) exp_ram[i] = ram0(i);
        repeat (3) @(negedge clk_sys);
        chk("rst_flags", 32'({bk_ena, bk_loading, bk_saving, sd_rd, sd_wr, bram_we}), 0);
        chk("rst_lba", sd_lba, 0);
        chk("rst_addr", 32'(bram_addr), 0);
        chk("rst_din", 32'(sd_buff_din), 0);
        chk("rst_wdata", 32'(bram_wdata), 0);
        reset = 1'b0;
        cmp_on = 1'b1;
        repeat (2) @(negedge clk_sys);
        stray = 1'b1;
        @(negedge clk_sys);
        stray = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("stray_ram0", 32'(ram[0]), 32'h0000A000);
        mount(64'd0, 1'b0);
        run_op("zero_size", 1'b1, 1'b0, 0, 0);
        mount(64'd32768, 1'b1);
        set_img(1);
        run_op("load64", 1'b1, 1'b0, 64, 0);
        chk("pin_ram0", 32'(ram[0]), 32'h00001000);
        chk("pin_ram300", 32'(ram[300]), 32'h000015DC);
        run_op("save64", 1'b0, 1'b1, 64, 3000);
        set_img(2);
        run_op("load2", 1'b1, 1'b0, 2, 0);
        chk("pin_ram100", 32'(ram[100]), 32'h000021F4);
        chk("pin_ram600", 32'(ram[600]), 32'h00001BB8);
        img_readonly = 1'b1;
        run_op("ro_save", 1'b0, 1'b1, 0, 0);
        img_readonly = 1'b0;
        mount(64'd1535, 1'b1);
        set_img(4);
        run_op("both", 1'b1, 1'b1, 2, 0);
        mount(64'd32768, 1'b1);
        set_img(3);
        @(negedge clk_sys);
        bk_load = 1'b1;
        t = 0;
        while (!(sd_ack && hps_lba == 5) && t < 5000) begin
            @(negedge clk_sys);
            t++;
        end
        chk("rstmid_reach", 32'(t < 5000), 1);
        repeat (10) @(negedge clk_sys);
        reset = 1'b1;
        m_ena = 1'b0;
        bk_load = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("rstmid_rd", 32'(sd_rd), 0);
        chk("rstmid_busy", 32'({bk_loading, bk_saving}), 0);
        chk("rstmid_we", 32'(bram_we), 0);
        chk("rstmid_addr", 32'(bram_addr), 0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b0;
        for (int i = 0; i < 5 * 256; i++) exp_ram[i] = img[i];
        repeat (5) @(negedge clk_sys);
        cmp_ram("rstmid_ram", 1280, 1536);
        chk("rstmid_ena", 32'(bk_ena), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
